// File: rtl/banner_pkg.sv
// Shared definitions for the sliding/blinking banner controller.
package banner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SLIDE = 3'd1,
    ST_HOLD  = 3'd2,
    ST_BLINK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DEF_CHAR_PITCH = 32;
  localparam int DEF_SCREEN_W   = 640;
  localparam int MAX_SLOTS      = 8;

  // Glyph count forced into 1..MAX_SLOTS.
  function automatic logic [3:0] clamp_len(input logic [3:0] m);
    if (m == 4'd0)
      return 4'd1;
    else if (m > 4'(MAX_SLOTS))
      return 4'(MAX_SLOTS);
    else
      return m;
  endfunction

endpackage

// File: rtl/banner_frame_counter.sv
// Frame tick counter with synchronous clear; tc pulses on the limit-th tick and the count wraps.
module frame_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         tick_en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count;

  assign tc = tick_en && (count == limit - W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (tick_en)
      count <= tc ? '0 : count + W'(1);
  end

endmodule

// File: rtl/banner_ctrl.sv
// Banner sequencer: slides a row of glyph slots in from the right, holds, blinks, then stays shown.
module banner_ctrl
  import banner_pkg::*;
#(
  parameter int SLIDE_STEP    = 8,
  parameter int HOLD_FRAMES   = 60,
  parameter int BLINK_FRAMES  = 15,
  parameter int BLINK_TOGGLES = 6,
  parameter int CHAR_PITCH    = DEF_CHAR_PITCH,
  parameter int SCREEN_W      = DEF_SCREEN_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] msg_len,
  input  logic [9:0] target_x,
  input  logic [9:0] target_y,
  output logic [9:0] base_x,
  output logic [9:0] base_y,
  output logic [7:0] slot_en,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_dbg
);

  state_t     state, state_n;
  logic [9:0] base_x_n, base_y_n, tx, tx_n, tx_c;
  logic [3:0] len, len_n, len_c;
  logic       visible, vis_n;
  logic [2:0] toggles, tog_n;
  logic [7:0] slot_en_n;
  logic       busy_n, done_n;
  logic       cnt_clear, cnt_en, cnt_tc;
  logic [7:0] cnt_limit;
  logic       slide_reached;
  int         lim_i;

  assign state_dbg = state;
  assign len_c     = clamp_len(msg_len);

  frame_counter #(.W(8)) u_frame_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .tick_en (cnt_en),
    .limit   (cnt_limit),
    .tc      (cnt_tc)
  );

  always_comb begin
    state_n   = state;
    base_x_n  = base_x;
    base_y_n  = base_y;
    tx_n      = tx;
    len_n     = len;
    vis_n     = visible;
    tog_n     = toggles;
    cnt_clear = 1'b0;
    cnt_en    = frame_tick && !abort && (state == ST_HOLD || state == ST_BLINK);
    cnt_limit = (state == ST_HOLD) ? 8'(HOLD_FRAMES) : 8'(BLINK_FRAMES);

    // Rightmost slot must stay on screen, so the landing x is capped.
    lim_i = SCREEN_W - int'(len_c) * CHAR_PITCH;
    if (int'(target_x) < lim_i)
      tx_c = target_x;
    else
      tx_c = 10'(lim_i);

    // Compare in 11 bits so base_x never wraps below tx.
    slide_reached = ({1'b0, base_x} <= ({1'b0, tx} + 11'(SLIDE_STEP)));

    if (abort) begin
      state_n   = ST_IDLE;
      vis_n     = 1'b0;
      tog_n     = 3'd0;
      cnt_clear = 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_n   = ST_SLIDE;
            len_n     = len_c;
            tx_n      = tx_c;
            base_y_n  = target_y;
            base_x_n  = 10'(SCREEN_W);
            vis_n     = 1'b1;
            tog_n     = 3'd0;
            cnt_clear = 1'b1;
          end
        end
        ST_SLIDE: begin
          if (frame_tick) begin
            if (slide_reached) begin
              base_x_n  = tx;
              state_n   = ST_HOLD;
              cnt_clear = 1'b1;
            end else begin
              base_x_n = base_x - 10'(SLIDE_STEP);
            end
          end
        end
        ST_HOLD: begin
          if (cnt_tc) begin
            state_n   = ST_BLINK;
            cnt_clear = 1'b1;
          end
        end
        ST_BLINK: begin
          if (cnt_tc) begin
            tog_n = toggles + 3'd1;
            if (toggles + 3'd1 == 3'(BLINK_TOGGLES)) begin
              vis_n   = 1'b1;
              state_n = ST_DONE;
            end else begin
              vis_n = ~visible;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end

    for (int i = 0; i < MAX_SLOTS; i++)
      slot_en_n[i] = vis_n && (state_n != ST_IDLE) && (i < int'(len_n));
    busy_n = (state_n == ST_SLIDE) || (state_n == ST_HOLD) || (state_n == ST_BLINK);
    done_n = (state_n == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      base_x  <= '0;
      base_y  <= '0;
      tx      <= '0;
      len     <= '0;
      visible <= 1'b0;
      toggles <= '0;
      slot_en <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      base_x  <= base_x_n;
      base_y  <= base_y_n;
      tx      <= tx_n;
      len     <= len_n;
      visible <= vis_n;
      toggles <= tog_n;
      slot_en <= slot_en_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_banner_ctrl.sv
// Directed bench for banner_ctrl: driver pushes expected output snapshots, monitor pops and compares.
module tb_banner_ctrl;

  logic       clk, reset;
  logic       frame_tick, start, abort;
  logic [3:0] msg_len;
  logic [9:0] target_x, target_y;
  logic [9:0] base_x, base_y;
  logic [7:0] slot_en;
  logic       busy, done;
  logic [2:0] state_dbg;

  logic [29:0] exp_q[$];
  logic [29:0] exp_v, act_v;
  string       name_q[$];
  string       nm;
  logic        obs_pulse;
  int          checks, errors;

  banner_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start      (start),
    .abort      (abort),
    .msg_len    (msg_len),
    .target_x   (target_x),
    .target_y   (target_y),
    .base_x     (base_x),
    .base_y     (base_y),
    .slot_en    (slot_en),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [29:0] pk(input int bx, input int by, input logic [7:0] se,
                                     input logic b, input logic d);
    return {10'(bx), 10'(by), se, b, d};
  endfunction

  // monitor / scoreboard
  always @(posedge obs_pulse) begin
    act_v = {base_x, base_y, slot_en, busy, done};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL no_expected actual bx=%0d by=%0d se=%h busy=%0b done=%0b",
               base_x, base_y, slot_en, busy, done);
    end else begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s actual bx=%0d by=%0d se=%h busy=%0b done=%0b required bx=%0d by=%0d se=%h busy=%0b done=%0b",
                 nm, act_v[29:20], act_v[19:10], act_v[9:2], act_v[1], act_v[0],
                 exp_v[29:20], exp_v[19:10], exp_v[9:2], exp_v[1], exp_v[0]);
      end
    end
  end

  task automatic observe(input string n, input logic [29:0] e);
    exp_q.push_back(e);
    name_q.push_back(n);
    obs_pulse = 1'b1;
    #1 obs_pulse = 1'b0;
  endtask

  // driver: inputs held over exactly one rising edge, outputs observed half a cycle later
  task automatic step(input string n, input logic t, input logic s, input logic a,
                      input logic [3:0] ml, input int tx, input int ty, input logic [29:0] e);
    @(negedge clk);
    frame_tick = t; start = s; abort = a;
    msg_len = ml; target_x = 10'(tx); target_y = 10'(ty);
    @(negedge clk);
    frame_tick = 1'b0; start = 1'b0; abort = 1'b0;
    observe(n, e);
  endtask

  task automatic tick(input string n, input logic [29:0] e);
    step(n, 1'b1, 1'b0, 1'b0, 4'd0, 0, 0, e);
  endtask

  int bx, t;
  logic [7:0] se;

  initial begin
    checks = 0; errors = 0; obs_pulse = 1'b0;
    frame_tick = 1'b0; start = 1'b0; abort = 1'b0;
    msg_len = 4'd0; target_x = '0; target_y = '0;
    reset = 1'b1;
    #12 observe("reset_state", pk(0, 0, 8'h00, 0, 0));
    @(negedge clk); reset = 1'b0;

    tick("idle_tick_ignored", pk(0, 0, 8'h00, 0, 0));

    // len 4, tx 100: start together with a tick, the tick must not step
    step("start_len4", 1'b1, 1'b1, 1'b0, 4'd4, 100, 200, pk(640, 200, 8'h0F, 1, 0));
    tick("slide_1", pk(632, 200, 8'h0F, 1, 0));
    step("start_in_slide_ignored", 1'b0, 1'b1, 1'b0, 4'd8, 10, 10, pk(632, 200, 8'h0F, 1, 0));
    for (int k = 2; k <= 68; k++) begin
      bx = 640 - 8 * k;
      if (bx < 100) bx = 100;
      tick($sformatf("slide_%0d", k), pk(bx, 200, 8'h0F, 1, 0));
    end
    for (int k = 1; k <= 60; k++)
      tick($sformatf("hold_%0d", k), pk(100, 200, 8'h0F, 1, 0));
    for (int j = 1; j <= 90; j++) begin
      t = j / 15;
      if (t == 6)
        tick("blink_done", pk(100, 200, 8'h0F, 0, 1));
      else begin
        se = (t % 2 == 0) ? 8'h0F : 8'h00;
        tick($sformatf("blink_%0d", j), pk(100, 200, se, 1, 0));
      end
    end
    tick("done_holds", pk(100, 200, 8'h0F, 0, 1));

    // len 8, tx 500 clamps to 384; restart from DONE
    step("start_len8", 1'b0, 1'b1, 1'b0, 4'd8, 500, 10, pk(640, 10, 8'hFF, 1, 0));
    for (int k = 1; k <= 32; k++)
      tick($sformatf("slide8_%0d", k), pk(640 - 8 * k, 10, 8'hFF, 1, 0));
    for (int k = 1; k <= 59; k++)
      tick($sformatf("hold8_%0d", k), pk(384, 10, 8'hFF, 1, 0));
    step("abort_beats_start", 1'b0, 1'b1, 1'b1, 4'd2, 0, 0, pk(384, 10, 8'h00, 0, 0));
    tick("idle_after_abort", pk(384, 10, 8'h00, 0, 0));

    // length clamping
    step("start_len0", 1'b0, 1'b1, 1'b0, 4'd0, 100, 5, pk(640, 5, 8'h01, 1, 0));
    tick("len0_slide", pk(632, 5, 8'h01, 1, 0));
    step("abort_slide", 1'b0, 1'b0, 1'b1, 4'd0, 0, 0, pk(632, 5, 8'h00, 0, 0));
    step("start_len12", 1'b0, 1'b1, 1'b0, 4'd12, 700, 7, pk(640, 7, 8'hFF, 1, 0));
    for (int k = 1; k <= 3; k++)
      tick($sformatf("len12_slide_%0d", k), pk(640 - 8 * k, 7, 8'hFF, 1, 0));

    // asynchronous reset between edges
    @(posedge clk); #2 reset = 1'b1;
    #1 observe("async_reset", pk(0, 0, 8'h00, 0, 0));
    @(negedge clk); reset = 1'b0;
    tick("post_reset_idle", pk(0, 0, 8'h00, 0, 0));
    step("restart_len2", 1'b0, 1'b1, 1'b0, 4'd2, 50, 60, pk(640, 60, 8'h03, 1, 0));
    tick("restart_slide", pk(632, 60, 8'h03, 1, 0));

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected actual %0d entries required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
